// File: rtl/meas_pkg.sv
// Shared types and sizing helpers for the measurement sequencer and its channel finder.
package meas_pkg;

  localparam int CNT_W = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SELECT  = 3'd1;
  localparam state_t ST_SETTLE  = 3'd2;
  localparam state_t ST_START   = 3'd3;
  localparam state_t ST_WAIT    = 3'd4;
  localparam state_t ST_CAPTURE = 3'd5;
  localparam state_t ST_PRESENT = 3'd6;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int chan_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/meas_chan_rr.sv
// Combinational finder for the next enabled channel above cur_ch and the lowest enabled channel.
module meas_chan_rr
  import meas_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = chan_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur_ch,
  output logic [CH_W-1:0]   next_ch,
  output logic              has_higher,
  output logic [CH_W-1:0]   lowest_ch,
  output logic              any_en
);

  logic [NUM_CH-1:0] above;

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_above
    assign above[gi] = mask[gi] && (CH_W'(gi) > cur_ch);
  end

  assign has_higher = |above;
  assign any_en     = |mask;

  // Scan downwards so the lowest qualifying index is the one left standing.
  always_comb begin
    next_ch   = '0;
    lowest_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (above[i]) next_ch = CH_W'(i);
      if (mask[i])  lowest_ch = CH_W'(i);
    end
  end

endmodule

// File: rtl/meas_sequencer.sv
// Sweeps the shared gated counter across enabled channels and presents each result on a valid/ready port.
// Define MEAS_SEQ_AVG_EN to average 2^AVG_LOG2 back-to-back measurements per channel.
module meas_sequencer
  import meas_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 400_000_000,
  parameter int AVG_LOG2       = 2,
  localparam int CH_W          = chan_w(NUM_CH)
) (
  input  logic              fbase,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic              cfg_continuous,
  input  logic [NUM_CH-1:0] cfg_chan_mask,
  input  logic              meas_done,
  input  logic [CNT_W-1:0]  fx_cnt_in,
  input  logic [CNT_W-1:0]  fbase_cnt_in,
  input  logic [CNT_W-1:0]  duty_cnt_in,
  input  logic [CNT_W-1:0]  delay_cnt_in,
  output logic [CH_W-1:0]   chan_sel,
  output logic              meas_start,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CH_W-1:0]   res_chan,
  output logic [CNT_W-1:0]  res_fx,
  output logic [CNT_W-1:0]  res_fbase,
  output logic [CNT_W-1:0]  res_duty,
  output logic [CNT_W-1:0]  res_delay,
  output logic              res_timeout
);

  localparam int SET_W       = cnt_w(SETTLE_CYCLES);
  localparam int TO_W        = cnt_w(TIMEOUT_CYCLES);
  localparam int SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam int TO_LAST     = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   cur_ch_reg, cur_ch_next;
  logic [CH_W-1:0]   chan_sel_reg;
  logic [SET_W-1:0]  settle_cnt_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic              done_d_reg;
  logic              to_flag_reg;
  logic [CH_W-1:0]   res_chan_reg;
  logic              res_timeout_reg;

  logic [CH_W-1:0]   rr_next_ch, rr_lowest_ch;
  logic              rr_has_higher, rr_any_en;
  logic              done_edge, timeout_hit, settle_last, last_meas, capture_en;
  logic [3:0][CNT_W-1:0] cnt_in;

  meas_chan_rr #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_rr (
    .mask       (cfg_chan_mask),
    .cur_ch     (cur_ch_reg),
    .next_ch    (rr_next_ch),
    .has_higher (rr_has_higher),
    .lowest_ch  (rr_lowest_ch),
    .any_en     (rr_any_en)
  );

  assign cnt_in      = {delay_cnt_in, duty_cnt_in, fbase_cnt_in, fx_cnt_in};
  assign done_edge   = meas_done && !done_d_reg;
  // The timeout counter includes the START cycle, so it equals cycles elapsed since meas_start.
  assign timeout_hit = to_cnt_reg >= TO_W'(TO_LAST);
  assign settle_last = settle_cnt_reg >= SET_W'(SETTLE_LAST);
  assign capture_en  = (state_reg == ST_CAPTURE) && !cmd_abort;

  always_comb begin
    state_next  = state_reg;
    cur_ch_next = cur_ch_reg;
    if (cmd_abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (cmd_start && rr_any_en) begin
          state_next  = ST_SELECT;
          cur_ch_next = rr_lowest_ch;
        end
        ST_SELECT:  state_next = (SETTLE_CYCLES == 0) ? ST_START : ST_SETTLE;
        ST_SETTLE:  if (settle_last) state_next = ST_START;
        ST_START:   state_next = ST_WAIT;
        ST_WAIT: begin
          if (done_edge)        state_next = last_meas ? ST_CAPTURE : ST_START;
          else if (timeout_hit) state_next = ST_CAPTURE;
        end
        ST_CAPTURE: state_next = ST_PRESENT;
        ST_PRESENT: if (res_ready) begin
          if (rr_has_higher) begin
            state_next  = ST_SELECT;
            cur_ch_next = rr_next_ch;
          end else if (cfg_continuous && rr_any_en) begin
            state_next  = ST_SELECT;
            cur_ch_next = rr_lowest_ch;
          end else begin
            state_next = ST_IDLE;
          end
        end
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge fbase or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      cur_ch_reg      <= '0;
      chan_sel_reg    <= '0;
      settle_cnt_reg  <= '0;
      to_cnt_reg      <= '0;
      done_d_reg      <= 1'b0;
      to_flag_reg     <= 1'b0;
      res_chan_reg    <= '0;
      res_timeout_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cur_ch_reg <= cur_ch_next;
      done_d_reg <= meas_done;
      if (state_reg == ST_SELECT) chan_sel_reg <= cur_ch_reg;
      if (state_reg == ST_SELECT)
        settle_cnt_reg <= '0;
      else if (state_reg == ST_SETTLE && !settle_last)
        settle_cnt_reg <= settle_cnt_reg + SET_W'(1);
      if (state_reg == ST_START)
        to_cnt_reg <= TO_W'(1);
      else if (state_reg == ST_WAIT && !timeout_hit)
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
      if (state_reg == ST_WAIT) to_flag_reg <= !done_edge && timeout_hit;
      if (capture_en) begin
        res_chan_reg    <= cur_ch_reg;
        res_timeout_reg <= to_flag_reg;
      end
    end
  end

`ifdef MEAS_SEQ_AVG_EN
  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 < 1) ? 1 : AVG_LOG2;

  logic [IDX_W-1:0] meas_idx_reg;

  assign last_meas = (meas_idx_reg == IDX_W'((1 << AVG_LOG2) - 1));

  always_ff @(posedge fbase or posedge rst) begin
    if (rst)
      meas_idx_reg <= '0;
    else if (state_reg == ST_SELECT)
      meas_idx_reg <= '0;
    else if (state_reg == ST_WAIT && done_edge && !last_meas)
      meas_idx_reg <= meas_idx_reg + IDX_W'(1);
  end
`else
  // AVG_LOG2 has no effect when averaging is compiled out.
  localparam int unused_avg_log2 = AVG_LOG2;
  assign last_meas = 1'b1;
`endif

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_cnt
    logic [CNT_W-1:0] cap_val;
    logic [CNT_W-1:0] res_reg;
`ifdef MEAS_SEQ_AVG_EN
    logic [ACC_W-1:0] acc_reg;
    always_ff @(posedge fbase or posedge rst) begin
      if (rst)
        acc_reg <= '0;
      else if (state_reg == ST_SELECT)
        acc_reg <= '0;
      else if (state_reg == ST_WAIT && done_edge)
        acc_reg <= acc_reg + ACC_W'(cnt_in[gi]);
    end
    assign cap_val = CNT_W'(acc_reg >> AVG_LOG2);
`else
    assign cap_val = cnt_in[gi];
`endif
    always_ff @(posedge fbase or posedge rst) begin
      if (rst)
        res_reg <= '0;
      else if (capture_en)
        res_reg <= to_flag_reg ? '0 : cap_val;
    end
  end

  assign chan_sel    = chan_sel_reg;
  assign meas_start  = (state_reg == ST_START);
  assign busy        = (state_reg != ST_IDLE);
  assign res_valid   = (state_reg == ST_PRESENT);
  assign res_chan    = res_chan_reg;
  assign res_timeout = res_timeout_reg;
  assign res_fx      = g_cnt[0].res_reg;
  assign res_fbase   = g_cnt[1].res_reg;
  assign res_duty    = g_cnt[2].res_reg;
  assign res_delay   = g_cnt[3].res_reg;

endmodule

// File: tb/tb_meas_sequencer.sv
// Randomized self-checking bench for meas_sequencer with a behavioural counter model and result scoreboard.
module tb_meas_sequencer;

  localparam int NUM_CH   = 4;
  localparam int CH_W     = 2;
  localparam int SETTLE   = 4;
  localparam int TIMEOUT  = 100;
  localparam int AVG_LOG2 = 2;
`ifdef MEAS_SEQ_AVG_EN
  localparam int AVG_N  = 1 << AVG_LOG2;
  localparam int AVG_SH = AVG_LOG2;
`else
  localparam int AVG_N  = 1;
  localparam int AVG_SH = 0;
`endif

  typedef struct packed {
    logic        to;
    logic [31:0] fx;
    logic [31:0] fb;
    logic [31:0] du;
    logic [31:0] de;
  } meas_t;

  logic              fbase = 1'b0;
  logic              rst;
  logic              cmd_start, cmd_abort, cfg_continuous;
  logic [NUM_CH-1:0] cfg_chan_mask;
  logic              meas_done;
  logic [31:0]       fx_cnt_in, fbase_cnt_in, duty_cnt_in, delay_cnt_in;
  logic [CH_W-1:0]   chan_sel, res_chan;
  logic              meas_start, busy, res_valid, res_ready, res_timeout;
  logic [31:0]       res_fx, res_fbase, res_duty, res_delay;

  meas_sequencer #(
    .NUM_CH(NUM_CH), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .fbase(fbase), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cfg_continuous(cfg_continuous), .cfg_chan_mask(cfg_chan_mask), .meas_done(meas_done),
    .fx_cnt_in(fx_cnt_in), .fbase_cnt_in(fbase_cnt_in), .duty_cnt_in(duty_cnt_in),
    .delay_cnt_in(delay_cnt_in), .chan_sel(chan_sel), .meas_start(meas_start), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan), .res_fx(res_fx),
    .res_fbase(res_fbase), .res_duty(res_duty), .res_delay(res_delay), .res_timeout(res_timeout)
  );

  always #5 fbase = ~fbase;

  int cyc = 0;
  always @(posedge fbase) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counter model: answers each meas_start with a done pulse carrying generated counts, or stays silent.
  meas_t mq[$];
  int    cnt_mode   = 0;   // 0 random, 1 fixed, 2 fx sequence
  bit    never_done = 0;
  bit    rand_to    = 0;
  int    seq_idx    = 0;
  int    start_cnt  = 0;
  int    start_cyc  = 0;
  int    done_cyc   = 0;

  initial begin : counter_model
    meas_t m;
    meas_done = 0;
    fx_cnt_in = 0; fbase_cnt_in = 0; duty_cnt_in = 0; delay_cnt_in = 0;
    forever begin
      @(negedge fbase);
      meas_done = 0;
      if (meas_start === 1'b1) begin
        start_cnt++;
        start_cyc = cyc;
        if (never_done || (rand_to && $urandom_range(0, 7) == 0)) begin
          m = '0;
          m.to = 1'b1;
          mq.push_back(m);
        end else begin
          repeat ($urandom_range(0, 7)) @(negedge fbase);
          @(negedge fbase);
          m.to = 1'b0;
          case (cnt_mode)
            1:       begin m.fx = 32'd1000; m.fb = 32'd200000000; m.du = 32'd123456; m.de = 32'd789; end
            2:       begin m.fx = 32'(10 + seq_idx); m.fb = 32'd5000; m.du = 32'd2500; m.de = 32'd42; seq_idx++; end
            default: begin m.fx = $urandom(); m.fb = $urandom(); m.du = $urandom(); m.de = $urandom(); end
          endcase
          fx_cnt_in = m.fx; fbase_cnt_in = m.fb; duty_cnt_in = m.du; delay_cnt_in = m.de;
          meas_done = 1;
          done_cyc = cyc;
          mq.push_back(m);
        end
      end
    end
  end

  logic [31:0] last_fx_exp;

  // Waits for a result and checks it against the averaged (or timed-out) measurements for this channel.
  task automatic expect_result(input int ch, input string tag);
    int          waited, got;
    bit          to;
    meas_t       m;
    logic [63:0] s0, s1, s2, s3;
    logic [31:0] e0, e1, e2, e3;
    waited = 0;
    while (res_valid !== 1'b1 && waited < 3000) begin
      @(negedge fbase);
      waited++;
    end
    chk({tag, "_valid"}, {63'b0, res_valid}, 64'd1);
    if (res_valid !== 1'b1) return;
    to = 0; got = 0; s0 = 0; s1 = 0; s2 = 0; s3 = 0;
    while (got < AVG_N && !to && mq.size() > 0) begin
      m = mq.pop_front();
      got++;
      if (m.to) to = 1;
      else begin s0 += m.fx; s1 += m.fb; s2 += m.du; s3 += m.de; end
    end
    chk({tag, "_nmeas"}, {63'b0, (to || got == AVG_N)}, 64'd1);
    e0 = to ? 32'd0 : 32'(s0 >> AVG_SH);
    e1 = to ? 32'd0 : 32'(s1 >> AVG_SH);
    e2 = to ? 32'd0 : 32'(s2 >> AVG_SH);
    e3 = to ? 32'd0 : 32'(s3 >> AVG_SH);
    chk({tag, "_chan"}, 64'(res_chan), 64'(ch));
    chk({tag, "_timeout"}, {63'b0, res_timeout}, {63'b0, to});
    chk({tag, "_fx"}, 64'(res_fx), 64'(e0));
    chk({tag, "_fbase"}, 64'(res_fbase), 64'(e1));
    chk({tag, "_duty"}, 64'(res_duty), 64'(e2));
    chk({tag, "_delay"}, 64'(res_delay), 64'(e3));
    if (to) chk({tag, "_lat_to"}, 64'(cyc - start_cyc), 64'(TIMEOUT + 1));
    else    chk({tag, "_lat_done"}, 64'(cyc - done_cyc), 64'd2);
    last_fx_exp = e0;
  endtask

  task automatic accept(input int hold);
    res_ready = 0;
    repeat (hold) @(negedge fbase);
    res_ready = 1;
    @(negedge fbase);
    res_ready = 0;
  endtask

  task automatic pulse_start();
    cmd_start = 1;
    @(negedge fbase);
    cmd_start = 0;
  endtask

  // Single sweep: expects one result per enabled channel in ascending order, then IDLE.
  task automatic run_sweep(input logic [NUM_CH-1:0] mask, input string tag, input int max_hold);
    cfg_chan_mask = mask;
    pulse_start();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (mask[ch]) begin
        expect_result(ch, $sformatf("%s_ch%0d", tag, ch));
        accept($urandom_range(0, max_hold));
      end
    end
    repeat (2) @(negedge fbase);
    chk({tag, "_idle_busy"}, {63'b0, busy}, 64'd0);
    chk({tag, "_mq_empty"}, 64'(mq.size()), 64'd0);
    mq.delete();
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          s0, waited;
    bit          stable, busy_seen;
    logic [31:0] snap_fx, snap_fb;
    logic [CH_W-1:0] snap_ch;
    logic [NUM_CH-1:0] rmask;
    logic [63:0] seq_sum;

    rst = 1; cmd_start = 0; cmd_abort = 0; cfg_continuous = 0;
    cfg_chan_mask = '0; res_ready = 0;
    repeat (3) @(negedge fbase);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_meas_start", {63'b0, meas_start}, 64'd0);
    chk("rst_res_valid", {63'b0, res_valid}, 64'd0);
    chk("rst_chan_sel", 64'(chan_sel), 64'd0);
    chk("rst_res_chan", 64'(res_chan), 64'd0);
    chk("rst_res_fx", 64'(res_fx), 64'd0);
    chk("rst_res_timeout", {63'b0, res_timeout}, 64'd0);
    rst = 0;
    @(negedge fbase);

    // Two-channel sweep with fixed counter values.
    cnt_mode = 1;
    run_sweep(4'b1010, "t1", 3);

    // Backpressure: result must hold while res_ready is low.
    cfg_chan_mask = 4'b0011;
    pulse_start();
    expect_result(0, "t2_first");
    snap_fx = res_fx; snap_fb = res_fbase; snap_ch = res_chan;
    s0 = start_cnt; stable = 1;
    repeat (50) begin
      @(negedge fbase);
      if (res_valid !== 1'b1 || res_fx !== snap_fx || res_fbase !== snap_fb || res_chan !== snap_ch)
        stable = 0;
    end
    chk("t2_hold_stable", {63'b0, stable}, 64'd1);
    chk("t2_hold_no_start", 64'(start_cnt - s0), 64'd0);
    accept(0);
    waited = 0;
    while (start_cnt == s0 && waited < 200) begin @(negedge fbase); waited++; end
    chk("t2_next_start", 64'(start_cnt - s0), 64'd1);
    expect_result(1, "t2_second");
    accept(0);
    repeat (2) @(negedge fbase);
    chk("t2_idle", {63'b0, busy}, 64'd0);
    mq.delete();

    // Timeout path.
    never_done = 1;
    cfg_chan_mask = 4'b0100;
    pulse_start();
    expect_result(2, "t3_to");
    accept(1);
    never_done = 0;
    repeat (2) @(negedge fbase);
    chk("t3_idle", {63'b0, busy}, 64'd0);
    mq.delete();

    // Continuous sweep on one channel, then abort during WAIT.
    cnt_mode = 0;
    cfg_continuous = 1;
    cfg_chan_mask = 4'b0001;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      expect_result(0, $sformatf("t4_rep%0d", k));
      if (k == 2) never_done = 1;
      s0 = start_cnt;
      accept($urandom_range(0, 4));
    end
    waited = 0;
    while (start_cnt == s0 && waited < 200) begin @(negedge fbase); waited++; end
    chk("t4_restart", 64'(start_cnt - s0), 64'd1);
    @(negedge fbase);
    cmd_abort = 1;
    @(negedge fbase);
    chk("t4_abort_busy", {63'b0, busy}, 64'd0);
    chk("t4_abort_valid", {63'b0, res_valid}, 64'd0);
    chk("t4_abort_start", {63'b0, meas_start}, 64'd0);
    chk("t4_abort_keep_fx", 64'(res_fx), 64'(last_fx_exp));
    cmd_abort = 0;
    cfg_continuous = 0;
    repeat (5) @(negedge fbase);
    chk("t4_stay_idle", {63'b0, busy}, 64'd0);
    never_done = 0;
    mq.delete();

    // Zero mask ignores cmd_start; then async reset while settling.
    cfg_chan_mask = '0;
    s0 = start_cnt; busy_seen = 0;
    cmd_start = 1;
    repeat (20) begin
      @(negedge fbase);
      if (busy !== 1'b0) busy_seen = 1;
    end
    cmd_start = 0;
    chk("t5_zero_mask_busy", {63'b0, busy_seen}, 64'd0);
    chk("t5_zero_mask_start", 64'(start_cnt - s0), 64'd0);
    cfg_chan_mask = 4'b0100;
    pulse_start();
    @(negedge fbase);
    chk("t5_settle_busy", {63'b0, busy}, 64'd1);
    chk("t5_settle_chan", 64'(chan_sel), 64'd2);
    #1 rst = 1;
    #1;
    chk("t5_arst_busy", {63'b0, busy}, 64'd0);
    chk("t5_arst_chan_sel", 64'(chan_sel), 64'd0);
    chk("t5_arst_res_chan", 64'(res_chan), 64'd0);
    chk("t5_arst_res_fx", 64'(res_fx), 64'd0);
    chk("t5_arst_valid", {63'b0, res_valid}, 64'd0);
    repeat (3) @(negedge fbase);
    rst = 0;
    @(negedge fbase);
    mq.delete();

    // fx sequence 10,11,12,...: averaged result and one start per averaged measurement.
    cnt_mode = 2; seq_idx = 0;
    seq_sum = 0;
    for (int k = 0; k < AVG_N; k++) seq_sum += 64'(10 + k);
    cfg_chan_mask = 4'b0001;
    s0 = start_cnt;
    pulse_start();
    expect_result(0, "t6_avg");
    chk("t6_avg_fx", 64'(res_fx), seq_sum >> AVG_SH);
    chk("t6_start_count", 64'(start_cnt - s0), 64'(AVG_N));
    accept(0);
    repeat (2) @(negedge fbase);
    mq.delete();

    // Randomized sweeps with random masks, counts, done delays, backpressure and timeouts.
    cnt_mode = 0;
    rand_to = 1;
    for (int t = 0; t < 25; t++) begin
      rmask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      run_sweep(rmask, $sformatf("rnd%0d", t), 5);
    end
    rand_to = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/meas_sequencer.md
Name: meas_sequencer

Overview:
Controller that sequences the shared gated frequency/duty/delay counter across NUM_CH input channels. It steers the channel select, pulses the counter's start, and waits for its done pulse, with a timeout. It then captures the four 32-bit counts and presents them, tagged with the channel, through a valid/ready result port. It sits between the register/command interface and the counter datapath, all on the fbase domain.

Parameters:
NUM_CH, 4, number of selectable input channels (2..16)
SETTLE_CYCLES, 16, fbase cycles waited after a channel switch before start
TIMEOUT_CYCLES, 400_000_000, max fbase cycles in WAIT before declaring timeout (2 s @ 200 MHz)
AVG_LOG2, 2, log2 of averaging depth (used only with MEAS_SEQ_AVG_EN)

Ports:
fbase  in  1  system clock (200 MHz); only clock
rst  in  1  asynchronous, active-high reset
cmd_start  in  1  level-sampled; begins a sweep when IDLE
cmd_abort  in  1  returns to IDLE from any state
cfg_continuous  in  1  1 = repeat sweeps indefinitely; 0 = one sweep
cfg_chan_mask  in  NUM_CH  enabled channels
meas_done  in  1  done pulse from counter
fx_cnt_in, fbase_cnt_in, duty_cnt_in, delay_cnt_in  in  32 each  counter results
chan_sel  out  clog2(NUM_CH)  channel mux select to counter
meas_start  out  1  one-cycle start pulse to counter
busy  out  1  high in any state except IDLE
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_chan  out  clog2(NUM_CH)  channel of result
res_fx, res_fbase, res_duty, res_delay  out  32 each  captured counts
res_timeout  out  1  result produced by timeout; counts are 0

Behaviour:
- Reset: state IDLE; chan_sel=0, meas_start=0, busy=0, res_valid=0, res_chan=0, all res_* counts=0, res_timeout=0.
- States: IDLE, SELECT, SETTLE, START, WAIT, CAPTURE, PRESENT.
- IDLE: cmd_start=1 with non-zero mask -> SELECT with cur_ch = lowest enabled channel. A zero mask ignores cmd_start; the block stays IDLE.
- SELECT (1 cycle): drive chan_sel=cur_ch, clear settle counter -> SETTLE.
- SETTLE: count SETTLE_CYCLES cycles -> START. SETTLE_CYCLES=0 skips directly to START.
- START (1 cycle): meas_start=1, clear timeout counter -> WAIT.
- WAIT: a rising edge of meas_done (edge-detected on posedge fbase, a 1-cycle registered history) -> CAPTURE. Timeout counter reaching TIMEOUT_CYCLES-1 with no edge -> CAPTURE with timeout flag set. When done and timeout coincide in the same cycle, done wins.
- CAPTURE (1 cycle): register the inputs into res_*, or zeros with res_timeout=1 on timeout; res_chan=cur_ch -> PRESENT with res_valid=1.
  - Latency: res_valid asserts exactly 2 cycles after the meas_done rising edge is sampled.
- PRESENT: hold res_valid and all res_* stable until res_valid&&res_ready. Acceptance clears res_valid on the next cycle; then:
  - next enabled channel above cur_ch exists -> SELECT it;
  - else cfg_continuous=1 -> SELECT the lowest enabled channel (wrap);
  - else -> IDLE.
- Mask is re-read at every channel advance. If the mask becomes zero mid-sweep, go to IDLE after the current result is accepted.
- cmd_abort: from any state, go to IDLE next cycle. res_valid and meas_start are forced 0; the res_* data registers keep their values. Abort has priority over cmd_start and res_ready.
- Async rst mid-measurement: all outputs return to reset values immediately.
- Counters saturate; none wrap.

Optional Feature:
MEAS_SEQ_AVG_EN
- Defined: each channel is measured 2^AVG_LOG2 times back-to-back (START->WAIT loop, no re-settle).
  - Counts accumulate in (32+AVG_LOG2)-bit registers.
  - CAPTURE outputs each sum right-shifted by AVG_LOG2 (truncated).
  - Any timeout ends the channel early with res_timeout=1 and counts 0.
- Undefined: single measurement per channel; no accumulators are synthesized.

Decomposition:
- meas_pkg: state enum, CNT_W=32, function for channel-index width, timeout/settle counter widths.
- Sub-module meas_chan_rr: combinational next-enabled-channel finder (inputs mask and cur_ch; outputs next_ch, has_higher, lowest_ch, any_en).

Test Plan:
1. mask=4'b1010, continuous=0, cmd_start pulse, counter model gives done with fx=1000/fbase=200000000 -> results for ch1 then ch3 with those values, res_timeout=0, then IDLE, busy=0.
2. Hold res_ready=0 for 50 cycles in PRESENT -> res_valid and data stay stable, no meas_start issued; res_ready=1 -> next SELECT.
3. Counter never returns done, TIMEOUT_CYCLES set to 100 -> res_timeout=1, counts=0, result appears 101 cycles after meas_start.
4. continuous=1, mask=4'b0001 -> repeated ch0 results; cmd_abort asserted during WAIT -> IDLE next cycle, res_valid=0.
5. mask=0 with cmd_start -> stays IDLE, meas_start never pulses; rst asserted during SETTLE -> all outputs return to reset values asynchronously.
6. MEAS_SEQ_AVG_EN, AVG_LOG2=2, fx counts 10,11,12,13 -> res_fx=11, exactly 4 meas_start pulses on one channel.
